// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the subordinate word memory.
// Holds the bus enums, the ERROR response code, the FSM state type
// and the byte-lane mask helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  localparam logic [1:0] ERR_RESP = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_t;

  // Little-endian byte enables for a legal (already checked) access.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << off;
      HSIZE_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slv_mem_bank.sv
// Word memory bank: DEPTH x 32 bits, four byte write enables,
// asynchronous (combinational) read. Contents are never reset.
module ahb_slv_mem_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Byte-lane write on the rising edge.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_we[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite subordinate word memory with programmable wait states,
// byte-lane writes and a two-cycle ERROR response for bad accesses.
// Optional feature macro: AHB_SLV_PROTECT_EN (write-protects words [0, RO_WORDS)).
// Handshake: an address phase is taken when HSel & HReady & HTrans[1]; a data
// phase completes on the edge where HReadyOut is high, and only then may the
// next address phase be taken (pipelined).
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [2:0]  HSize,
  input  logic [31:0] HWData,
  input  logic        HReady,
  output logic [31:0] HRData,
  output logic        HReadyOut,
  output logic [1:0]  HResp,
  output logic [1:0]  o_dbg_state
);

  localparam int         ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  slv_state_t        r_state, w_next;
  logic [3:0]        r_wcnt, w_wcnt_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic              r_write;
  logic [2:0]        r_size;

  htrans_t     w_trans;
  logic [29:0] w_word_idx;
  logic        w_accept, w_err, w_range_err, w_align_err, w_size_err, w_prot_err;
  logic        w_phase_end, w_done;
  logic [3:0]  w_we;
  logic [31:0] w_rdata;

  assign w_trans    = htrans_t'(HTrans);
  assign w_accept   = HSel && HReady && (w_trans == HTRANS_NONSEQ || w_trans == HTRANS_SEQ);
  assign w_word_idx = HAddr[31:2];

  // Address-phase checks; the full address is range-checked so a burst that
  // runs off the end errors instead of aliasing back to word 0.
  assign w_range_err = (w_word_idx >= 30'(MEM_DEPTH));
  assign w_align_err = ((HSize == HSIZE_HALF) && HAddr[0]) ||
                       ((HSize == HSIZE_WORD) && (HAddr[1:0] != 2'b00));
  assign w_size_err  = (HSize > HSIZE_WORD);
`ifdef AHB_SLV_PROTECT_EN
  assign w_prot_err  = HWrite && (w_word_idx < 30'(RO_WORDS));
`else
  localparam int unused_ro_words = RO_WORDS;
  assign w_prot_err  = 1'b0;
`endif
  assign w_err = w_range_err || w_align_err || w_size_err || w_prot_err;

  // State, wait counter and captured address-phase controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
      r_addr  <= '0;
      r_off   <= 2'b00;
      r_write <= 1'b0;
      r_size  <= 3'b000;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_next;
      if (w_accept && w_phase_end) begin
        r_addr  <= w_word_idx[ADDR_W-1:0];
        r_off   <= HAddr[1:0];
        r_write <= HWrite;
        r_size  <= HSize;
      end
    end
  end

  // Next state, wait counting and bus response.
  always_comb begin
    w_next      = r_state;
    w_wcnt_next = r_wcnt;
    HReadyOut   = 1'b1;
    HResp       = HRESP_OKAY;
    w_phase_end = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: w_phase_end = 1'b1;
      ST_DATA: begin
        if (r_wcnt < WS) begin
          HReadyOut   = 1'b0;
          w_wcnt_next = r_wcnt + 4'd1;
        end else begin
          w_done      = 1'b1;
          w_phase_end = 1'b1;
          w_wcnt_next = 4'd0;
        end
      end
      ST_ERR1: begin
        HReadyOut = 1'b0;
        HResp     = ERR_RESP;
        w_next    = ST_ERR2;
      end
      ST_ERR2: begin
        HResp       = ERR_RESP;
        w_phase_end = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_phase_end) begin
      if (w_accept) w_next = w_err ? ST_ERR1 : ST_DATA;
      else          w_next = ST_IDLE;
    end
  end

  assign w_we        = {4{w_done && r_write}} & lane_mask(r_size, r_off);
  assign HRData      = (w_done && !r_write) ? w_rdata : 32'd0;
  assign o_dbg_state = r_state;

  ahb_slv_mem_bank #(
    .DEPTH(MEM_DEPTH),
    .AW   (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .i_addr (r_addr),
    .i_we   (w_we),
    .i_wdata(HWData),
    .o_rdata(w_rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: two instances (WAIT_STATES 0 and 2),
// directed scenarios followed by randomized pipelined traffic scored against
// a transaction-level memory model.
module tb_ahb_slave_mem;

  localparam int DEPTH = 256;
  localparam int RO    = 16;
`ifdef AHB_SLV_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic [1:0]  hresp     [2];
  logic [1:0]  dbg_state [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_slave_mem #(
      .MEM_DEPTH  (DEPTH),
      .WAIT_STATES((g == 0) ? 0 : 2),
      .RO_WORDS   (RO)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .HSel       (hsel[g]),
      .HAddr      (haddr[g]),
      .HTrans     (htrans[g]),
      .HWrite     (hwrite[g]),
      .HSize      (hsize[g]),
      .HWData     (hwdata[g]),
      .HReady     (hreadyout[g]),
      .HRData     (hrdata[g]),
      .HReadyOut  (hreadyout[g]),
      .HResp      (hresp[g]),
      .o_dbg_state(dbg_state[g])
    );
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } item_t;

  typedef struct packed {
    logic   err;
    int     waits;
    logic   chk;
  } meta_t;

  item_t       items  [$];
  meta_t       meta_q [$];
  logic [31:0] exp_q  [$];
  logic [31:0] mdl    [2][DEPTH];
  bit          known  [2][DEPTH];
  int          ws_of  [2] = '{0, 2};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rdata;
  int          low_cycles;
  int          run_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic item_t mk(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    item_t it;
    it.sel = sel; it.trans = trans; it.addr = addr; it.wr = wr; it.size = size; it.wdata = wdata;
    return it;
  endfunction

  // Bad-access rules stated in terms of byte address and transfer size.
  function automatic bit is_bad(input item_t it);
    int unsigned idx;
    idx = it.addr / 4;
    if (idx >= DEPTH) return 1'b1;
    if (it.size > 3'd2) return 1'b1;
    if ((it.addr % (32'd1 << it.size)) != 0) return 1'b1;
    if (PROT && it.wr && idx < RO) return 1'b1;
    return 1'b0;
  endfunction

  // Queue one transfer for device d and derive its expected outcome in order.
  task automatic push(input int d, input item_t it);
    meta_t       m;
    logic [31:0] e;
    bit          acc;
    int unsigned idx, off, nb;
    acc   = it.sel && it.trans[1];
    m.err = acc && is_bad(it);
    m.waits = !acc ? 0 : (m.err ? 1 : ws_of[d]);
    m.chk = 1'b1;
    e     = 32'd0;
    idx   = it.addr / 4;
    if (acc && !m.err) begin
      if (!it.wr) begin
        e     = mdl[d][idx];
        m.chk = known[d][idx];
      end else begin
        off = it.addr % 4;
        nb  = 1 << it.size;
        for (int b = 0; b < 4; b++) begin
          if (b >= off && b < off + nb) mdl[d][idx][8*b +: 8] = it.wdata[8*b +: 8];
        end
        if (nb == 4) known[d][idx] = 1'b1;
      end
    end
    items.push_back(it);
    meta_q.push_back(m);
    exp_q.push_back(e);
  endtask

  task automatic bus_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = 32'd0;
    hwrite[d] = 1'b0; hsize[d] = 3'd0;
  endtask

  // ---------------- driver ----------------
  // Pipelined master: address of item i overlaps the data phase of item i-1.
  task automatic run(input int d);
    item_t       cur;
    meta_t       m;
    logic [31:0] e;
    bit          cur_v, rdy;
    int          waits, i, n;
    cur_v = 1'b0; waits = 0; i = 0; n = items.size();
    e = 32'd0; m = '0; cur = '0;
    run_cycles = 0; low_cycles = 0;
    while (i < n || cur_v) begin
      if (i < n) begin
        hsel[d] = items[i].sel; htrans[d] = items[i].trans; haddr[d] = items[i].addr;
        hwrite[d] = items[i].wr; hsize[d] = items[i].size;
      end else begin
        bus_idle(d);
      end
      hwdata[d] = cur_v ? cur.wdata : $urandom;
      @(negedge clk);
      run_cycles++;
      rdy = hreadyout[d];
      if (cur_v) begin
        check("resp", 32'(hresp[d]), m.err ? 32'd1 : 32'd0);
        if (!rdy) begin
          low_cycles++;
          waits++;
          check("rdata_stall", hrdata[d], 32'd0);
          if (waits > 40) begin
            check("timeout", 32'(waits), 32'(m.waits));
            break;
          end
        end else begin
          check("wait", 32'(waits), 32'(m.waits));
          if (m.chk) check("rdata", hrdata[d], e);
          last_rdata = hrdata[d];
          waits = 0;
        end
      end else begin
        check("idle_ready", 32'(hreadyout[d]), 32'd1);
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        if (i < n) begin
          cur = items[i]; m = meta_q.pop_front(); e = exp_q.pop_front();
          cur_v = 1'b1; i++;
        end else begin
          cur_v = 1'b0;
        end
      end
    end
    bus_idle(d);
    items.delete(); meta_q.delete(); exp_q.delete();
  endtask

  function automatic item_t rand_item();
    item_t it;
    int    r;
    it.sel = ($urandom_range(0, 9) != 0);
    r = $urandom_range(0, 9);
    it.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
    it.wr = 1'($urandom_range(0, 1));
    it.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    it.addr = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1016, 1040)) : 32'($urandom_range(0, 127));
    if ($urandom_range(0, 2) != 0 && it.size <= 3'd2) it.addr = it.addr & ~((32'd1 << it.size) - 32'd1);
    it.wdata = $urandom;
    return it;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      bus_idle(d);
      hwdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(hreadyout[d]), 32'd1);
      check("rst_resp",  32'(hresp[d]),     32'd0);
      check("rst_rdata", hrdata[d],         32'd0);
    end
    @(posedge clk); #1;

    // Zero-wait write then read of the same word, back to back.
    push(0, mk(1, 2'b10, 32'h08, 1, 3'd2, 32'hAABBCCDD));
    push(0, mk(1, 2'b10, 32'h08, 0, 3'd2, 32'h0));
    run(0);
    check("t2_rdata", last_rdata, 32'hAABBCCDD);
    check("t2_stalls", 32'(low_cycles), 32'd0);

    // Two-wait-state burst read of four words.
    for (int k = 0; k < 4; k++) push(1, mk(1, 2'b10, 32'(4 * k), 1, 3'd2, $urandom));
    run(1);
    push(1, mk(1, 2'b10, 32'h00, 0, 3'd2, 32'h0));
    for (int k = 1; k < 4; k++) push(1, mk(1, 2'b11, 32'(4 * k), 0, 3'd2, 32'h0));
    run(1);
    check("t3_cycles", 32'(run_cycles), 32'd13);
    check("t3_stalls", 32'(low_cycles), 32'd8);

    // Byte-lane write into word 1.
    push(0, mk(1, 2'b10, 32'h04, 1, 3'd2, 32'h11223344));
    push(0, mk(1, 2'b10, 32'h05, 1, 3'd0, 32'h0000EE00));
    push(0, mk(1, 2'b10, 32'h04, 0, 3'd2, 32'h0));
    run(0);
`ifndef AHB_SLV_PROTECT_EN
    check("t4_byte", last_rdata, 32'h1122EE44);
`endif

    // Misaligned word read gives the two-cycle ERROR, then idle OKAY.
    push(1, mk(1, 2'b10, 32'h02, 0, 3'd2, 32'h0));
    push(1, mk(0, 2'b00, 32'h00, 0, 3'd0, 32'h0));
    run(1);
    check("t5_stalls", 32'(low_cycles), 32'd1);

    // Write to word 4 (protected only when the feature is built in).
    push(0, mk(1, 2'b10, 32'h10, 1, 3'd2, 32'h1));
    push(0, mk(1, 2'b10, 32'h10, 0, 3'd2, 32'h0));
    run(0);
`ifdef AHB_SLV_PROTECT_EN
    check("t6_stalls", 32'(low_cycles), 32'd1);
`else
    check("t6_rdata", last_rdata, 32'h1);
    check("t6_stalls", 32'(low_cycles), 32'd0);
`endif

    // Top word is fine, the next one is out of range.
    push(0, mk(1, 2'b10, 32'h3FC, 1, 3'd2, 32'h5A5A1234));
    push(0, mk(1, 2'b11, 32'h400, 0, 3'd2, 32'h0));
    push(0, mk(1, 2'b10, 32'h3FC, 0, 3'd2, 32'h0));
    run(0);
    check("range_rdata", last_rdata, 32'h5A5A1234);
    check("range_stalls", 32'(low_cycles), 32'd1);

    // Reset during a write data phase must drop the write.
    push(1, mk(1, 2'b10, 32'h50, 1, 3'd2, 32'hCAFEF00D));
    run(1);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h50; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk); #1;
    bus_idle(1);
    hwdata[1] = 32'h0BADBEEF;
    @(negedge clk);
    check("mr_stall", 32'(hreadyout[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push(1, mk(1, 2'b10, 32'h50, 0, 3'd2, 32'h0));
    run(1);
    check("mr_rdata", last_rdata, 32'hCAFEF00D);

    // Randomized pipelined traffic on both devices.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 32; k++) push(d, mk(1, 2'b10, 32'(4 * k), 1, 3'd2, $urandom));
      run(d);
      for (int k = 0; k < 200; k++) push(d, rand_item());
      run(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
